// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the interval timer family.
// Count width is tied to the fan-in of the downstream zero-detect NOR.
package timer_pkg;

  localparam int TMR_W = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_e;

endpackage

// File: rtl/timer7_down_if.sv
// Control/status bundle between a timer7_down and the logic that drives it.
// master: sequencer side; slave: the timer itself.
interface timer7_down_if;
  import timer_pkg::*;

  logic             ld;
  logic             en;
  logic [TMR_W-1:0] din;
  logic [TMR_W-1:0] cnt;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output ld, en, din, input cnt, zero, busy, done);
  modport slave  (input ld, en, din, output cnt, zero, busy, done);

endinterface

// File: rtl/mynor7inp.sv
// 7-input NOR zero detect on the timer count; built from a gate primitive
// so the netlist carries a single NOR cell rather than a reduction tree.
module mynor7inp (
  input  logic [6:0] a,
  output wire        y
);

  nor u_nor7 (y, a[0], a[1], a[2], a[3], a[4], a[5], a[6]);

endmodule

// File: rtl/timer7_down.sv
// 7-bit loadable down-counter with busy, one-cycle done and optional auto-reload.
// state | meaning:  IDLE | no run, en ignored;  RUN | counting toward zero
module timer7_down
  import timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  timer7_down_if.slave  bus
);

  localparam int WIDTH = TMR_W;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  tmr_state_e       state;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] rld_q;
  logic             done_q;
  logic             zero_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt_q  <= CNT_ZERO;
      rld_q  <= CNT_ZERO;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ld) begin
            cnt_q <= bus.din;
            rld_q <= bus.din;
            if (bus.din != CNT_ZERO) state <= RUN;
          end
        end
        RUN: begin
          // A load on the completing edge wins and suppresses done.
          if (bus.ld) begin
            cnt_q <= bus.din;
            rld_q <= bus.din;
            if (bus.din == CNT_ZERO) state <= IDLE;
          end else if (bus.en) begin
            // Only reachable with auto-reload: the one cycle spent at zero.
            if (cnt_q == CNT_ZERO) cnt_q <= rld_q;
            else                   cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              done_q <= 1'b1;
              if (!AUTO_RELOAD) state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mynor7inp u_nor (
    .a (cnt_q),
    .y (zero_w)
  );

  assign bus.cnt  = cnt_q;
  assign bus.zero = zero_w;
  assign bus.busy = (state == RUN);
  assign bus.done = done_q;

endmodule

// File: tb/tb_timer7_down.sv
// Self-checking bench for timer7_down: one instance without and one with auto-reload.
module tb_timer7_down;

  logic clk;
  logic rst_n;

  timer7_down_if if0 ();
  timer7_down_if if1 ();

  timer7_down #(.AUTO_RELOAD(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  timer7_down #(.AUTO_RELOAD(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct {
    bit         sel;
    logic       ld;
    logic       en;
    logic [6:0] din;
    logic [6:0] cnt;
    logic       busy;
    logic       done;
  } vec_t;

  typedef struct {
    string      name;
    bit         sel;
    logic [6:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(bit sel, logic ld, logic en, logic [6:0] din,
                     logic [6:0] cnt, logic busy, logic done);
    vec_t v;
    v.sel = sel; v.ld = ld; v.en = en; v.din = din;
    v.cnt = cnt; v.busy = busy; v.done = done;
    vecs.push_back(v);
  endtask

  task automatic drive(bit sel, logic ld, logic en, logic [6:0] din);
    if (sel) begin
      if1.ld = ld; if1.en = en; if1.din = din;
      if0.ld = 1'b0; if0.en = 1'b0; if0.din = 7'd0;
    end else begin
      if0.ld = ld; if0.en = en; if0.din = din;
      if1.ld = 1'b0; if1.en = 1'b0; if1.din = 7'd0;
    end
  endtask

  task automatic expect_out(string name, bit sel, logic [6:0] cnt, logic busy, logic done);
    exp_t e;
    e.name = name; e.sel = sel; e.cnt = cnt; e.busy = busy; e.done = done;
    exp_q.push_back(e);
  endtask

  task automatic compare_one();
    exp_t       e;
    logic [6:0] a_cnt;
    logic       a_busy, a_done, a_zero, e_zero;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    if (e.sel) begin
      a_cnt = if1.cnt; a_busy = if1.busy; a_done = if1.done; a_zero = if1.zero;
    end else begin
      a_cnt = if0.cnt; a_busy = if0.busy; a_done = if0.done; a_zero = if0.zero;
    end
    e_zero = (e.cnt == 7'd0);
    if (a_cnt !== e.cnt || a_busy !== e.busy || a_done !== e.done || a_zero !== e_zero) begin
      errors++;
      $display("FAIL %s (dut%0d) @%0t: got cnt=%0d busy=%b done=%b zero=%b, want cnt=%0d busy=%b done=%b zero=%b",
               e.name, e.sel, $time, a_cnt, a_busy, a_done, a_zero, e.cnt, e.busy, e.done, e_zero);
    end
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next falling edge.
  task automatic step(string name, bit sel, logic ld, logic en, logic [6:0] din,
                      logic [6:0] cnt, logic busy, logic done);
    drive(sel, ld, en, din);
    expect_out(name, sel, cnt, busy, done);
    @(posedge clk);
    @(negedge clk);
    compare_one();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 7'd0);
    if1.ld = 1'b0; if1.en = 1'b0; if1.din = 7'd0;
    rst_n = 1'b1;

    // basic run of 5
    add(0, 1, 0, 7'd5, 7'd5, 1, 0);
    add(0, 0, 1, 7'd0, 7'd4, 1, 0);
    add(0, 0, 1, 7'd0, 7'd3, 1, 0);
    add(0, 0, 1, 7'd0, 7'd2, 1, 0);
    add(0, 0, 1, 7'd0, 7'd1, 1, 0);
    add(0, 0, 1, 7'd0, 7'd0, 0, 1);
    add(0, 0, 1, 7'd0, 7'd0, 0, 0);
    add(0, 0, 1, 7'd0, 7'd0, 0, 0);
    // hold, then restart mid-run
    add(0, 1, 0, 7'd10, 7'd10, 1, 0);
    add(0, 0, 1, 7'd0,  7'd9,  1, 0);
    add(0, 0, 0, 7'd0,  7'd9,  1, 0);
    add(0, 0, 0, 7'd0,  7'd9,  1, 0);
    add(0, 0, 1, 7'd0,  7'd8,  1, 0);
    add(0, 1, 1, 7'd3,  7'd3,  1, 0);
    add(0, 0, 1, 7'd0,  7'd2,  1, 0);
    add(0, 0, 1, 7'd0,  7'd1,  1, 0);
    add(0, 0, 1, 7'd0,  7'd0,  0, 1);
    add(0, 0, 1, 7'd0,  7'd0,  0, 0);
    // load of zero from idle and from run
    add(0, 1, 1, 7'd0, 7'd0, 0, 0);
    add(0, 0, 1, 7'd0, 7'd0, 0, 0);
    add(0, 1, 0, 7'd6, 7'd6, 1, 0);
    add(0, 0, 1, 7'd0, 7'd5, 1, 0);
    add(0, 1, 1, 7'd0, 7'd0, 0, 0);
    add(0, 0, 1, 7'd0, 7'd0, 0, 0);
    // shortest run
    add(0, 1, 0, 7'd1, 7'd1, 1, 0);
    add(0, 0, 1, 7'd0, 7'd0, 0, 1);
    add(0, 0, 1, 7'd0, 7'd0, 0, 0);
    // load colliding with completion
    add(0, 1, 0, 7'd2, 7'd2, 1, 0);
    add(0, 0, 1, 7'd0, 7'd1, 1, 0);
    add(0, 1, 1, 7'd4, 7'd4, 1, 0);
    add(0, 0, 1, 7'd0, 7'd3, 1, 0);
    add(0, 0, 0, 7'd0, 7'd3, 1, 0);

    // reset state
    #2 rst_n = 1'b0;
    #7;
    expect_out("reset_dut0", 0, 7'd0, 0, 0);
    compare_one();
    expect_out("reset_dut1", 1, 7'd0, 0, 0);
    compare_one();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].sel, vecs[i].ld, vecs[i].en, vecs[i].din,
           vecs[i].cnt, vecs[i].busy, vecs[i].done);

    // full-scale run: no wrap, done after exactly 127 enabled edges
    step("max_load", 0, 1, 0, 7'd127, 7'd127, 1, 0);
    for (int i = 1; i < 127; i++)
      step("max_count", 0, 0, 1, 7'd0, 7'(127 - i), 1, 0);
    step("max_done", 0, 0, 1, 7'd0, 7'd0, 0, 1);
    step("max_after", 0, 0, 1, 7'd0, 7'd0, 0, 0);

    // auto-reload: period of rld+1 enabled cycles, busy stays high
    step("ar_load", 1, 1, 1, 7'd2, 7'd2, 1, 0);
    for (int i = 0; i < 9; i++) begin
      logic [6:0] ec;
      ec = 7'(2 - ((i + 1) % 3));
      step("ar_period", 1, 0, 1, 7'd0, ec, 1, (ec == 7'd0));
    end
    step("ar_hold", 1, 0, 0, 7'd0, 7'd2, 1, 0);
    step("ar_stop", 1, 1, 0, 7'd0, 7'd0, 0, 0);

    // asynchronous reset mid-run aborts without done
    step("pre_rst_load", 0, 1, 0, 7'h25, 7'h25, 1, 0);
    drive(0, 1'b0, 1'b1, 7'd0);
    #2 rst_n = 1'b0;
    #6;
    expect_out("rst_midrun", 0, 7'd0, 0, 0);
    compare_one();
    @(posedge clk);
    @(negedge clk);
    expect_out("rst_held", 0, 7'd0, 0, 0);
    compare_one();
    rst_n = 1'b1;
    step("post_rst", 0, 0, 1, 7'd0, 7'd0, 0, 0);

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: got %0d unchecked entries, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
